// File: rtl/gcd_seq.sv
// Multi-cycle binary (Stein) GCD with valid/ready handshakes on both sides; one reduction step per clock.
// Optional CALC cycle counter on port 'cycles' when GCD_CYCLE_CNT_EN is defined.
module gcd_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] gcd
`ifdef GCD_CYCLE_CNT_EN
  ,
  output logic [15:0]  cycles
`endif
);

  localparam int KW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [KW-1:0] k;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)              state_nxt = CALC;
      CALC:    if (x == '0 || y == '0)    state_nxt = DONE;
      DONE:    if (out_ready)             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // k counts common factors of two; the final shift restores them
  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      k   <= '0;
      gcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x <= a;
            y <= b;
            k <= '0;
          end
        end
        CALC: begin
          if (x == '0) begin
            gcd <= y << k;
          end else if (y == '0) begin
            gcd <= x << k;
          end else if (!x[0] && !y[0]) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + KW'(1);
          end else if (!x[0]) begin
            x <= x >> 1;
          end else if (!y[0]) begin
            y <= y >> 1;
          end else if (x >= y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else if (state == IDLE && in_valid) begin
      cycles <= '0;
    end else if (state == CALC && cycles != 16'hFFFF) begin
      cycles <= cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_seq.sv
// Scoreboard bench for gcd_seq: W=7 and W=16 instances, directed vectors, decoupled result monitors.
module tb_gcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic [15:0] opa;
  logic [15:0] opb;

  logic        in_valid7, in_ready7, out_valid7;
  logic [6:0]  a7, b7, gcd7;
  logic        in_valid16, in_ready16, out_valid16;
  logic [15:0] a16, b16, gcd16;
`ifdef GCD_CYCLE_CNT_EN
  logic [15:0] cycles7, cycles16;
`endif

  assign in_valid7  = in_valid & ~sel;
  assign in_valid16 = in_valid & sel;
  assign a7  = opa[6:0];
  assign b7  = opb[6:0];
  assign a16 = opa;
  assign b16 = opb;

  logic        in_ready_m, out_valid_m;
  logic [15:0] gcd_m;
  assign in_ready_m  = sel ? in_ready16  : in_ready7;
  assign out_valid_m = sel ? out_valid16 : out_valid7;
  assign gcd_m       = sel ? gcd16 : {9'd0, gcd7};

  gcd_seq #(.W(7)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7),
    .a(a7), .b(b7), .out_valid(out_valid7), .out_ready(out_ready), .gcd(gcd7)
`ifdef GCD_CYCLE_CNT_EN
    , .cycles(cycles7)
`endif
  );

  gcd_seq #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready), .gcd(gcd16)
`ifdef GCD_CYCLE_CNT_EN
    , .cycles(cycles16)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] q7[$];
  logic [15:0] q16[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid7 && out_ready) begin
      if (q7.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon7_unexpected got %0d expected none", gcd7);
      end else begin
        check("mon7_gcd", 32'(gcd7), 32'(q7.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon16_unexpected got %0d expected none", gcd16);
      end else begin
        check("mon16_gcd", 32'(gcd16), 32'(q16.pop_front()));
      end
    end
  end

  // exp_lat/exp_cyc < 0 means "check only the 4W+2 bound" / "no cycle check"
  task automatic do_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] ex, input int exp_lat, input int exp_cyc,
                       input int hold);
    int lat, bad, bound;
    logic seen;
    logic [15:0] g;
    bound = s ? 66 : 30;
    @(posedge clk);
    #1;
    sel = s; opa = av; opb = bv; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready_m), 32'd1);
    @(posedge clk);
    if (s) q16.push_back(ex);
    else   q7.push_back(ex);
    #1 in_valid = 1'b0;
    lat = 0; bad = 0; seen = 1'b0;
    while (!seen && lat < bound + 10) begin
      @(negedge clk);
      lat++;
      if (in_ready_m) bad++;
      if (out_valid_m) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout got no out_valid after %0d cycles expected <= %0d", lat, bound);
      return;
    end
    if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
    else              check("latency_bound", 32'(lat <= bound), 32'd1);
    if (exp_cyc >= 0) begin
`ifdef GCD_CYCLE_CNT_EN
      check("cycles", 32'(s ? cycles16 : cycles7), 32'(exp_cyc));
`endif
    end
    if (hold > 0) begin
      g = gcd_m;
      repeat (hold) begin
        @(posedge clk);
        #1 in_valid = 1'b1; opa = 16'd3; opb = 16'd5;
        @(negedge clk);
        if (gcd_m !== g || !out_valid_m || in_ready_m) bad++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
    end
    check("busy_hold", 32'(bad), 32'd0);
    @(negedge clk);
    check("release_in_ready", 32'(in_ready_m), 32'd1);
    check("release_out_valid", 32'(out_valid_m), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic rose;
    rst = 1'b1; in_valid = 1'b1; opa = 16'd90; opb = 16'd86; sel = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready7), 32'd1);
      check("rst_out_valid", 32'(out_valid7), 32'd0);
      check("rst_gcd", 32'(gcd7), 32'd0);
    end
    check("rst_gcd16", 32'(gcd16), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("no_start_in_ready", 32'(in_ready7), 32'd1);
    check("no_start_out_valid", 32'(out_valid7), 32'd0);

    do_op(0, 90, 86, 2, -1, -1, 0);
    do_op(0, 48, 12, 12, -1, -1, 0);
    do_op(0, 65, 4, 1, -1, -1, 0);
    do_op(0, 48, 7, 1, -1, -1, 0);
    // (8,2): both-even, x even, x even, x-y, x==0 -> 5 CALC cycles
    do_op(0, 8, 2, 2, 6, 5, 0);
    do_op(0, 125, 6, 1, -1, -1, 0);
    do_op(0, 85, 76, 1, -1, -1, 0);
    do_op(0, 54, 44, 2, -1, -1, 0);
    do_op(0, 95, 32, 1, -1, -1, 0);
    do_op(0, 109, 91, 1, -1, -1, 0);
    do_op(0, 75, 34, 1, -1, -1, 0);

    do_op(0, 0, 0, 0, 2, 1, 0);
    do_op(0, 0, 37, 37, 2, 1, 0);
    do_op(0, 37, 37, 37, 3, 2, 0);
    do_op(0, 0, 5, 5, 2, 1, 0);
    do_op(1, 65535, 65535, 65535, 3, 2, 0);
    do_op(1, 32768, 49152, 16384, 20, 19, 0);

    do_op(0, 90, 86, 2, -1, -1, 10);

    @(posedge clk);
    #1 sel = 1'b0; opa = 16'd109; opb = 16'd91; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid7) rose = 1'b1;
    end
    check("abort_no_out", 32'(rose), 32'd0);
    check("abort_in_ready", 32'(in_ready7), 32'd1);
    do_op(0, 48, 12, 12, -1, -1, 0);

    repeat (2) @(negedge clk);
    check("queue7_drained", 32'(q7.size()), 32'd0);
    check("queue16_drained", 32'(q16.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
